// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor controller: diff = a - b - borrow_in, one bit per clock, LSB first.
// Define SERIAL_SUB_OVF_EN to add the signed overflow output.
//
// state | meaning
// IDLE  | waiting for start; result registers hold the last result
// RUN   | one full-subtractor step per edge, borrow carried in br
// DONE  | one-cycle done pulse; result registers freshly loaded
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sh, b_sh, r_sh;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             ai, bi, d_bit, b_nxt;
  logic [WIDTH-1:0] r_done;

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb, b_msb;
`endif

  assign ai     = a_sh[0];
  assign bi     = b_sh[0];
  assign d_bit  = ai ^ bi ^ br;
  assign b_nxt  = (~ai & bi) | (~ai & br) | (bi & br);
  assign last   = (cnt == CW'(WIDTH - 1));
  assign r_done = {d_bit, r_sh[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh       <= '0;
      b_sh       <= '0;
      r_sh       <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      overflow   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            br    <= borrow_in;
            cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
            // operand MSBs are shifted away during RUN, so keep them for the flag
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
`endif
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          r_sh <= r_done;
          br   <= b_nxt;
          if (last) begin
            diff       <= r_done;
            borrow_out <= b_nxt;
`ifdef SERIAL_SUB_OVF_EN
            overflow   <= (a_msb ^ b_msb) & (a_msb ^ d_bit);
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl: directed table, corner sequences and random ops
// against an arithmetic reference model. Honours SERIAL_SUB_OVF_EN when defined.
module tb_serial_sub_ctrl;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             borrow_in;
  logic             busy, done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
`ifdef SERIAL_SUB_OVF_EN
  logic             overflow;
`endif

  int tests = 0;
  int fails = 0;

  serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .a(a),
    .b(b),
    .borrow_in(borrow_in),
    .busy(busy),
    .done(done),
    .diff(diff),
    .borrow_out(borrow_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .overflow(overflow)
`endif
  );

  always #5 clk = ~clk;

  // start must be known whenever the controller can accept it
  always @(posedge clk) begin
    if (!rst && !busy && !done)
      assert (!$isunknown(start)) else $error("start is X/Z while idle");
  end

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic [WIDTH-1:0] exp_diff;
    logic             exp_bout;
    logic             exp_ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands
  task automatic model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb, input logic mbin,
                       output logic [WIDTH-1:0] d, output logic bo, output logic ov);
    int ia, ib, ibin, r;
    ia = int'(ma); ib = int'(mb); ibin = int'(mbin);
    r  = ia - ib - ibin;
    d  = WIDTH'(r);
    bo = (ia < ib + ibin);
    ov = (ma[WIDTH-1] ^ mb[WIDTH-1]) & (ma[WIDTH-1] ^ d[WIDTH-1]);
  endtask

  // One full operation from IDLE: checks busy window, done pulse and results
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v, input logic tbin,
                        input logic [WIDTH-1:0] ed, input logic eb, input logic eo, input string nm);
    int busy_cnt;
    busy_cnt = 0;
    @(negedge clk);
    a = ta; b = tb_v; borrow_in = tbin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~ta; b = ~tb_v; borrow_in = ~tbin;
    for (int i = 0; i < WIDTH; i++) begin
      if (busy && !done) busy_cnt++;
      @(posedge clk); #1;
    end
    chk({nm, ".busy_cycles"}, busy_cnt, WIDTH);
    chk({nm, ".done"}, {busy, done}, 2'b01);
    chk({nm, ".diff"}, diff, ed);
    chk({nm, ".borrow_out"}, borrow_out, eb);
`ifdef SERIAL_SUB_OVF_EN
    chk({nm, ".overflow"}, overflow, eo);
`else
    if (eo === 1'bx) $display("unused overflow expectation");
`endif
    @(posedge clk); #1;
    chk({nm, ".done_len"}, done, 1'b0);
    chk({nm, ".hold"}, diff, ed);
  endtask

  initial begin
    logic [WIDTH-1:0] md, ra, rb;
    logic mb, mo, rbin;
    int ndone, last_idx, overlap;

    vecs[0] = '{8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0};
    vecs[1] = '{8'h12, 8'h35, 1'b0, 8'hDD, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 8'h01, 1'b0, 8'hFE, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[5] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[7] = '{8'h00, 8'hFF, 1'b0, 8'h01, 1'b1, 1'b0};
    vecs[8] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.busy", busy, 1'b0);
    chk("reset.done", done, 1'b0);
    chk("reset.diff", diff, '0);
    chk("reset.borrow_out", borrow_out, 1'b0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].exp_diff, vecs[i].exp_bout,
             vecs[i].exp_ovf, $sformatf("vec%0d", i));

    // Start re-pulsed during RUN must be ignored
    @(negedge clk);
    a = 8'h35; b = 8'h12; borrow_in = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    a = 8'hFF; b = 8'h01; start = 1'b1;
    @(negedge clk); start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        chk("repulse.diff", diff, 8'h23);
      end
    end
    chk("repulse.done_count", ndone, 1);
    run_op(8'hFF, 8'h01, 1'b0, 8'hFE, 1'b0, 1'b0, "after_repulse");

    // start held high: back-to-back ops every WIDTH+2 cycles
    @(negedge clk);
    a = 8'h10; b = 8'h01; borrow_in = 1'b0; start = 1'b1;
    ndone = 0; last_idx = -1; overlap = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (busy && done) overlap++;
      if (done) begin
        ndone++;
        chk("held.diff", diff, 8'h0F);
        if (last_idx >= 0) chk("held.period", i - last_idx, WIDTH + 2);
        last_idx = i;
      end
    end
    start = 1'b0;
    chk("held.done_count", ndone, 3);
    chk("held.overlap", overlap, 0);
    repeat (WIDTH + 3) @(posedge clk);
    #1;

    // Async reset mid-operation after the 4th processing edge
    @(negedge clk);
    a = 8'h35; b = 8'h12; borrow_in = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #3; rst = 1'b1;
    #1;
    chk("abort.busy", busy, 1'b0);
    chk("abort.diff", diff, 8'h00);
    chk("abort.done", done, 1'b0);
    @(negedge clk); rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < WIDTH + 4; i++) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    chk("abort.no_activity", ndone, 0);
    run_op(8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, "after_abort");

    // Random operations against the reference model
    for (int i = 0; i < 40; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rbin = 1'($urandom_range(0, 1));
      model(ra, rb, rbin, md, mb, mo);
      run_op(ra, rb, rbin, md, mb, mo, $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
